rr_stream_merge: RTL and testbench
==================================

Name: rr_stream_merge

Overview:
- Round-robin arbitrated N-to-1 stream merger with a registered output stage.
- Selects one of INPUTS valid/ready producers per cycle, captures its word and its source index, and presents them downstream.
- out_src drives the sel input of downstream demux/mux stages, so the merged word can be steered back per-source.
- Generates its own mux select internally; no external select logic is needed.

Parameters:
- INPUTS, 4: number of producer ports; must be >= 2; need not be a power of two.
- WIDTH, 8: data word width in bits.

Ports:
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  INPUTS  per-producer valid; bit i belongs to port i.
- in_ready  output  INPUTS  per-producer accept; combinational from state and in_valid.
- in_data  input  WIDTH x INPUTS (unpacked array [INPUTS-1:0])  per-producer data words.
- out_valid  output  1  registered output word valid.
- out_ready  input  1  downstream accept.
- out_data  output  WIDTH  registered merged word.
- out_src  output  $clog2(INPUTS)  index of the port that supplied out_data.

Behaviour:
- Reset (reset low, asynchronous): out_valid=0, out_data=0, out_src=0, priority pointer ptr=0. in_ready is 0 while reset is asserted.
- load = !out_valid || out_ready. The output register accepts a new word only when load=1.
- Grant: scan ports ptr, ptr+1, ... modulo INPUTS (not 2^n), and grant the first i with in_valid[i]=1. At most one grant per cycle.
- in_ready[i] = load && grant[i]. All other in_ready bits are 0. A transfer on port i occurs when in_valid[i] && in_ready[i].
- On a transfer from port i at posedge:
  - out_data <= in_data[i]
  - out_src <= i
  - out_valid <= 1
  - ptr <= (i+1) mod INPUTS; wraps from INPUTS-1 to 0.
- load=1 with no in_valid: out_valid <= 0. out_data, out_src and ptr hold their values.
- Stall (out_valid=1, out_ready=0): out_data, out_src, out_valid and ptr all hold; every in_ready=0.
- Simultaneous downstream pop and new grant in the same cycle: the new word replaces the old one; out_valid stays 1. Throughput is 1 word/cycle.
- Latency: 1 cycle from an accepted input to out_valid.
- Fairness: a port held valid is granted within INPUTS transfers.
- Pointer update: ptr moves only on a transfer, never on idle or stall cycles.
- Producer contract: in_valid held until accepted. The block does not rely on this, and withdrawing in_valid is not an error.
- Reset mid-stall: the pending word is dropped, all outputs return to reset values, and ptr returns to 0.

Test Plan:
- Reset values: assert reset low with random in_valid/in_data and out_ready=1 -> out_valid=0, out_data=0, out_src=0, in_ready=0 for the whole reset period. First grant after release goes to port 0 if it is valid.
- Single requester: INPUTS=4, only port 2 valid with data 8'hA5, out_ready=1 -> in_ready=4'b0100, and the next cycle shows out_valid=1, out_data=8'hA5, out_src=2. Sustained port 2 traffic yields 1 word/cycle.
- Full contention: all 4 ports valid continuously, data = port index, out_ready=1 -> out_src sequence 0,1,2,3,0,1,... with no gaps.
- Backpressure: word from port 1 registered, then out_ready=0 for 3 cycles -> out_data/out_src/out_valid stable, in_ready=0, ptr unchanged. On out_ready=1, the pending word pops and port 2 (next after 1) is granted that same cycle.
- Non-power-of-two wrap: INPUTS=3, ports 0 and 2 valid -> grant order 0,2,0,2. The pointer wraps 2->0 and never indexes 3.
- Reset mid-stall: out_valid=1, out_ready=0, ptr=3, then pulse reset low for one cycle -> outputs return to reset values immediately (asynchronous), and after release the first grant follows ptr=0 ordering.

Source files
------------

// File: rtl/rr_stream_merge.sv
// rr_stream_merge: round-robin N-to-1 valid/ready stream merger with a
// registered output stage.
//
// Each cycle, this block picks at most one valid producer. The search starts
// at a rotating priority pointer and wraps modulo INPUTS. When the output
// register can load, the chosen word is captured together with the index of
// its source. Downstream logic can then use out_src to steer the word back
// per source.
//
// Ports:
//   clock      sole clock, posedge
//   reset      asynchronous active-low reset
//   in_valid   per-producer valid, bit i = port i
//   in_ready   per-producer accept (combinational from state and in_valid)
//   in_data    per-producer data words
//   out_valid  registered output valid
//   out_ready  downstream accept
//   out_data   registered merged word
//   out_src    index of the port that supplied out_data
module rr_stream_merge #(
   parameter int unsigned INPUTS = 4,
   parameter int unsigned WIDTH  = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [INPUTS-1:0]         in_valid,
   output logic [INPUTS-1:0]         in_ready,
   input  logic [WIDTH-1:0]          in_data [INPUTS-1:0],
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [$clog2(INPUTS)-1:0] out_src
);

   localparam int unsigned SrcW  = $clog2(INPUTS);
   // One extra bit: ptr + offset can reach 2*INPUTS-2 before the wrap.
   localparam int unsigned CandW = SrcW + 1;

   logic [SrcW-1:0]   ptr_q, ptr_d;
   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  out_data_q, out_data_d;
   logic [SrcW-1:0]   out_src_q, out_src_d;

   logic              load;
   logic              grant_any;
   logic [SrcW-1:0]   grant_idx;
   logic [INPUTS-1:0] grant;
   logic [CandW-1:0]  cand_w;
   logic [SrcW-1:0]   cand;

   // The output register may take a new word when it is empty or is being
   // popped in this same cycle.
   assign load = ~out_valid_q | out_ready;

   // Rotating-priority search. Candidate indices are reduced modulo INPUTS,
   // so a non-power-of-two port count never reaches an index past INPUTS-1.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand_w    = '0;
      cand      = '0;
      for (int unsigned k = 0; k < INPUTS; k++) begin
         cand_w = {1'b0, ptr_q} + CandW'(k);
         if (cand_w >= CandW'(INPUTS)) begin
            cand_w = cand_w - CandW'(INPUTS);
         end
         cand = cand_w[SrcW-1:0];
         if (!grant_any && in_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_comb begin
      grant            = '0;
      grant[grant_idx] = grant_any;
   end

   // Gate with reset so that no producer sees an accept while the block is held in reset.
   assign in_ready = (load && reset) ? grant : '0;

   always_comb begin
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      if (load) begin
         if (grant_any) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[grant_idx];
            out_src_d   = grant_idx;
            ptr_d       = (grant_idx == SrcW'(INPUTS - 1)) ? '0 : grant_idx + SrcW'(1);
         end else begin
            // The register is drained and nothing new arrives. Data, source
            // and pointer keep their last values.
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_stream_merge.sv
// Directed testbench for rr_stream_merge.
// u4 is the default 4-port, 8-bit instance.
// u3 is a 3-port instance that exercises the non-power-of-two pointer wrap.
module tb_rr_stream_merge;

   logic       clock;
   logic       reset;

   logic [3:0] v4;
   logic [3:0] r4;
   logic [7:0] d4 [3:0];
   logic       ov4;
   logic       or4;
   logic [7:0] od4;
   logic [1:0] os4;

   logic [2:0] v3;
   logic [2:0] r3;
   logic [7:0] d3 [2:0];
   logic       ov3;
   logic       or3;
   logic [7:0] od3;
   logic [1:0] os3;

   int tests;
   int fails;

   rr_stream_merge #(.INPUTS(4), .WIDTH(8)) u4 (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (v4),
      .in_ready  (r4),
      .in_data   (d4),
      .out_valid (ov4),
      .out_ready (or4),
      .out_data  (od4),
      .out_src   (os4)
   );

   rr_stream_merge #(.INPUTS(3), .WIDTH(8)) u3 (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (v3),
      .in_ready  (r3),
      .in_data   (d3),
      .out_valid (ov3),
      .out_ready (or3),
      .out_data  (od3),
      .out_src   (os3)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b0;
      v4    = 4'($urandom_range(1, 15));
      or4   = 1'b1;
      for (int i = 0; i < 4; i++) d4[i] = 8'($urandom);
      v3    = '0;
      or3   = 1'b1;
      for (int i = 0; i < 3; i++) d3[i] = 8'h30 + 8'(i);

      // Reset values held for the whole reset period
      #1;
      for (int c = 0; c < 3; c++) begin
         chk("rst_valid", ov4, 0);
         chk("rst_data", od4, 0);
         chk("rst_src", os4, 0);
         chk("rst_ready", r4, 0);
         chk("rst_valid3", ov3, 0);
         v4 = 4'($urandom_range(1, 15));
         tick();
      end

      // Release: first grant goes to port 0
      reset = 1'b1;
      for (int i = 0; i < 4; i++) d4[i] = 8'h10 + 8'(i);
      v4 = 4'b0101;
      #1;
      chk("first_ready", r4, 4'b0001);
      tick();
      chk("first_valid", ov4, 1);
      chk("first_src", os4, 0);
      chk("first_data", od4, 8'h10);

      // Single requester on port 2, sustained at 1 word/cycle
      v4 = 4'b0100;
      for (int k = 0; k < 4; k++) begin
         d4[2] = 8'hA5 + 8'(k);
         #1;
         chk("single_ready", r4, 4'b0100);
         tick();
         chk("single_valid", ov4, 1);
         chk("single_src", os4, 2);
         chk("single_data", od4, 8'hA5 + k);
      end

      // Reset pulse, then full contention: src 0,1,2,3,0,1 with no gaps
      reset = 1'b0;
      #1;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) d4[i] = 8'(i);
      v4 = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("cont_ready", r4, 32'(1) << (k % 4));
         tick();
         chk("cont_valid", ov4, 1);
         chk("cont_src", os4, k % 4);
         chk("cont_data", od4, k % 4);
      end

      // Backpressure: the word from port 1 is held for 3 cycles
      or4 = 1'b0;
      #1;
      chk("bp_ready0", r4, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("bp_valid", ov4, 1);
         chk("bp_src", os4, 1);
         chk("bp_data", od4, 1);
         chk("bp_ready", r4, 0);
      end
      or4 = 1'b1;
      #1;
      chk("bp_pop_ready", r4, 4'b0100);
      tick();
      chk("bp_pop_src", os4, 2);
      chk("bp_pop_data", od4, 2);
      chk("bp_pop_valid", ov4, 1);

      // Reset mid-stall with ptr=3
      or4 = 1'b0;
      tick();
      chk("ms_hold_src", os4, 2);
      reset = 1'b0;
      #1;
      chk("ms_valid", ov4, 0);
      chk("ms_data", od4, 0);
      chk("ms_src", os4, 0);
      chk("ms_ready", r4, 0);
      tick();
      chk("ms_valid_held", ov4, 0);
      reset = 1'b1;
      or4   = 1'b1;
      v4    = 4'b1010;
      #1;
      chk("ms_after_ready", r4, 4'b0010);
      tick();
      chk("ms_after_src", os4, 1);
      chk("ms_after_data", od4, 1);

      // Idle cycle: valid drops, data/src/ptr hold
      v4 = 4'b0000;
      #1;
      chk("idle_ready", r4, 0);
      tick();
      chk("idle_valid", ov4, 0);
      chk("idle_src", os4, 1);
      chk("idle_data", od4, 1);
      v4 = 4'b1010;
      #1;
      chk("idle_ptr_ready", r4, 4'b1000);
      tick();
      chk("idle_ptr_src", os4, 3);
      v4 = 4'b0000;

      // Three-port instance: ports 0 and 2 valid give grants 0,2,0,2
      v3 = 3'b101;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("np2_ready", r3, (k % 2 == 0) ? 3'b001 : 3'b100);
         tick();
         chk("np2_valid", ov3, 1);
         chk("np2_src", os3, (k % 2 == 0) ? 0 : 2);
         chk("np2_data", od3, (k % 2 == 0) ? 8'h30 : 8'h32);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
